error_frame_block: RTL and testbench
====================================

# error_frame_block

Error-signalling and fault-confinement stage directly downstream of the error detector in the CAN receive path. It consumes the combined active-low `ERROR` indication at sample points and generates the CAN error frame on the transmit line: error flag, dominant-superposition wait, and error delimiter. It also maintains the receive error counter (REC) and the error-passive status that selects between active and passive error flags.

## Interface
- `FLAG_LEN`, default 6: error-flag length in bit times.
- `DELIM_LEN`, default 8: error-delimiter length in recessive bit times.
- `REC_W`, default 8: REC width; the counter saturates at all-ones.
- `clock` input, 1 bit: single system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `SP` input, 1 bit: one-cycle sample-point strobe; all state advances only on cycles with `SP`=1.
- `RX` input, 1 bit: sampled bus level; 0 is dominant.
- `ERROR` input, 1 bit: active-low; 0 at an SP means an error was detected (combined form/EOF/stuff).
- `FRAME_OK` input, 1 bit: pulse at an SP; a frame was received without error.
- `TX_ERR` output, 1 bit: registered bus drive; 0 is dominant, 1 is recessive/idle.
- `ERR_ACTIVE` output, 1 bit: an error frame is in progress.
- `ERR_DONE` output, 1 bit: one-cycle pulse when the delimiter completes.
- `REC` output, `REC_W` bits: receive error counter.
- `ERR_PASSIVE` output, 1 bit: high when `REC` ≥ 128.

## Operation
- States: `IDLE`, `FLAG`, `SUPER`, `DELIM`.
- **IDLE**
  - An SP with `ERROR`=0 moves to `FLAG`, clears the bit counter, and increments REC by 1.
  - `TX_ERR` becomes 0 if error-active, or stays 1 if error-passive.
- **FLAG**
  - Each SP increments the bit counter.
  - On the `FLAG_LEN`-th SP, move to `SUPER` and set `TX_ERR`=1.
- **SUPER** (waits for the bus to release)
  - SP with `RX`=1: move to `DELIM`; the delimiter count starts at 1.
  - SP with `RX`=0 and it is the first SP in `SUPER`: REC += 8.
  - Every further 8 consecutive dominant SPs: REC += 8.
- **DELIM**
  - SP with `RX`=1 increments the delimiter count.
  - When the count reaches `DELIM_LEN`: move to `IDLE` and pulse `ERR_DONE`.
  - SP with `RX`=0 is a delimiter form error: re-enter `FLAG` with counters cleared, REC += 1, and no `ERR_DONE`.
- `ERROR` is ignored outside `IDLE`.
- `FRAME_OK` is honoured only in `IDLE` on an SP without an error:
  - REC > 127 → REC = 120.
  - Otherwise, if REC > 0 → REC − 1.
- Simultaneous `ERROR`=0 and `FRAME_OK` on one SP: the error wins and there is no decrement.
- REC arithmetic saturates at 2^`REC_W`−1; no wrap-around.
- `ERR_PASSIVE` is combinational from REC (bit 7).
- The passive/active flag type is latched when `FLAG` is entered and held for the whole flag.
- `ERR_ACTIVE` is high in `FLAG`, `SUPER` and `DELIM`.

## Timing
- Reset values: state `IDLE`, `TX_ERR`=1, `ERR_ACTIVE`=0, `ERR_DONE`=0, `REC`=0, `ERR_PASSIVE`=0.
- Reset assertion mid-frame aborts the frame immediately and asynchronously; `TX_ERR` returns to 1.
- All outputs are registered except `ERR_PASSIVE`.
- Outputs change in the cycle after the SP that caused them and hold until the next SP.
- Latency from an `ERROR` SP to the first dominant `TX_ERR` is 1 clock.
- Minimum frame with `RX` following `TX_ERR`:
  - `FLAG_LEN` + `DELIM_LEN` bit times, i.e. 14 SPs.
  - `ERR_DONE` is high for exactly one clock after the 14th SP.

## Structure
- Shared package holds:
  - state encoding;
  - `FLAG_LEN_DEF`=6, `DELIM_LEN_DEF`=8;
  - `REC_PASSIVE_LIMIT`=128, `REC_RECOVER`=120;
  - `REC_INC_ERR`=1, `REC_INC_DOM`=8.
- One natural sub-module, `rec_counter`, owns REC:
  - inputs: increment-by-1, increment-by-8, decrement/recover;
  - saturation logic;
  - output `ERR_PASSIVE`.
- The FSM and bit/delimiter counters stay in the top level.

## Test plan
- **Reset:** assert `reset`=0 in the middle of `FLAG` → `TX_ERR`=1, `ERR_ACTIVE`=0, `REC`=0 at once; after release, state is `IDLE`.
- **Basic error frame:** `ERROR`=0 at one SP, with `RX` looped from `TX_ERR` → `TX_ERR`=0 for 6 SPs, then 1 for 8 SPs; `ERR_DONE` pulses once after SP 14; `REC`=1.
- **Superposition:** after the flag, drive `RX`=0 for 9 SPs, then 1 → `REC`=1+8+8=17; delimiter completes 8 SPs after the first recessive SP.
- **Error-passive:** 15 frames with first-`SUPER`-bit dominant (REC=135) → `ERR_PASSIVE`=1 and the next flag keeps `TX_ERR`=1. Then `FRAME_OK` → `REC`=120 and `ERR_PASSIVE`=0.
- **Delimiter form error:** drive `RX`=0 on the 4th delimiter SP → `FLAG` restarts with `TX_ERR`=0 next cycle; REC incremented by 1; no `ERR_DONE`.
- **Simultaneous events and saturation:**
  - `ERROR`=0 and `FRAME_OK`=1 on the same SP with REC=5 → REC=6.
  - REC=250 plus a dominant first `SUPER` bit → REC=255 (saturates).

Source files
------------

// File: rtl/error_frame_block_pkg.sv
// Shared types and constants for the CAN error-frame generator and its
// receive error counter.
package error_frame_block_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLAG  = 2'd1,
        ST_SUPER = 2'd2,
        ST_DELIM = 2'd3
    } efb_state_e;

    localparam int FLAG_LEN_DEF      = 6;
    localparam int DELIM_LEN_DEF     = 8;
    localparam int REC_PASSIVE_LIMIT = 128;
    localparam int REC_RECOVER       = 120;
    localparam int REC_INC_ERR       = 1;
    localparam int REC_INC_DOM       = 8;
    localparam int DOM_RUN_LEN       = 8;

endpackage

// File: rtl/error_frame_block_if.sv
// Sample-point side bus of the error-frame block: receive-path strobes in,
// transmit drive and fault-confinement status out.
interface error_frame_block_if #(
    parameter int REC_W = 8
);
    logic             SP;
    logic             RX;
    logic             ERROR;
    logic             FRAME_OK;
    logic             TX_ERR;
    logic             ERR_ACTIVE;
    logic             ERR_DONE;
    logic [REC_W-1:0] REC;
    logic             ERR_PASSIVE;

    modport master (
        output SP, RX, ERROR, FRAME_OK,
        input  TX_ERR, ERR_ACTIVE, ERR_DONE, REC, ERR_PASSIVE
    );

    modport slave (
        input  SP, RX, ERROR, FRAME_OK,
        output TX_ERR, ERR_ACTIVE, ERR_DONE, REC, ERR_PASSIVE
    );
endinterface

// File: rtl/error_frame_block_rec_counter.sv
// Receive error counter: saturating +1/+8 increments, decrement or recovery
// to 120 on a good frame, and the derived error-passive status.
module error_frame_block_rec_counter
    import error_frame_block_pkg::*;
#(
    parameter int REC_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_err,
    input  logic             inc_dom,
    input  logic             dec,
    output logic [REC_W-1:0] rec,
    output logic             err_passive
);

    logic [REC_W-1:0] rec_d;
    logic [REC_W-1:0] rec_q;
    logic [REC_W-1:0] step_s;
    logic [REC_W:0]   sum_s;

    // Next counter value; the extra sum bit flags an overflow to saturate on
    always_comb begin
        if (inc_dom) begin
            step_s = REC_W'(REC_INC_DOM);
        end else if (inc_err) begin
            step_s = REC_W'(REC_INC_ERR);
        end else begin
            step_s = {REC_W{1'b0}};
        end
        sum_s = {1'b0, rec_q} + {1'b0, step_s};
        rec_d = rec_q;
        if (inc_dom || inc_err) begin
            if (sum_s[REC_W]) begin
                rec_d = {REC_W{1'b1}};
            end else begin
                rec_d = sum_s[REC_W-1:0];
            end
        end else if (dec) begin
            if (rec_q >= REC_W'(REC_PASSIVE_LIMIT)) begin
                rec_d = REC_W'(REC_RECOVER);
            end else if (rec_q != {REC_W{1'b0}}) begin
                rec_d = rec_q - REC_W'(1);
            end else begin
                rec_d = rec_q;
            end
        end else begin
            rec_d = rec_q;
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rec_q <= {REC_W{1'b0}};
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec         = rec_q;
    assign err_passive = (rec_q >= REC_W'(REC_PASSIVE_LIMIT));

endmodule

// File: rtl/error_frame_block.sv
// CAN error-frame generator: error flag, dominant-superposition wait and
// error delimiter, driving the fault-confinement counter.
module error_frame_block
    import error_frame_block_pkg::*;
#(
    parameter int FLAG_LEN  = FLAG_LEN_DEF,
    parameter int DELIM_LEN = DELIM_LEN_DEF,
    parameter int REC_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    error_frame_block_if.slave bus
);

    localparam int CNT_MAX = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLAG_LAST     = CNT_W'(FLAG_LEN);
    localparam logic [CNT_W-1:0] DELIM_LAST    = CNT_W'(DELIM_LEN);
    localparam logic [2:0]       DOM_RUN_LAST  = 3'(DOM_RUN_LEN - 1);

    efb_state_e       state_d, state_q;
    logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_inc_s;
    logic [2:0]       dom_cnt_d, dom_cnt_q;
    logic             super_first_d, super_first_q;
    logic             flag_passive_d, flag_passive_q;
    logic             tx_err_d, tx_err_q;
    logic             err_active_d, err_active_q;
    logic             err_done_d, err_done_q;
    logic             inc_err_s, inc_dom_s, dec_s;
    logic             passive_s;
    logic [REC_W-1:0] rec_s;

    // Next-state, counter and output logic; everything advances only on SP
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        dom_cnt_d      = dom_cnt_q;
        super_first_d  = super_first_q;
        flag_passive_d = flag_passive_q;
        tx_err_d       = tx_err_q;
        err_done_d     = 1'b0;
        inc_err_s      = 1'b0;
        inc_dom_s      = 1'b0;
        dec_s          = 1'b0;
        bit_cnt_inc_s  = bit_cnt_q + CNT_W'(1);
        if (bus.SP) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.ERROR) begin
                        state_d        = ST_FLAG;
                        bit_cnt_d      = {CNT_W{1'b0}};
                        inc_err_s      = 1'b1;
                        flag_passive_d = passive_s;
                        tx_err_d       = passive_s;
                    end else if (bus.FRAME_OK) begin
                        dec_s = 1'b1;
                    end else begin
                        dec_s = 1'b0;
                    end
                end
                ST_FLAG: begin
                    bit_cnt_d = bit_cnt_inc_s;
                    if (bit_cnt_inc_s == FLAG_LAST) begin
                        state_d       = ST_SUPER;
                        tx_err_d      = 1'b1;
                        super_first_d = 1'b1;
                        dom_cnt_d     = 3'd0;
                    end else begin
                        tx_err_d = flag_passive_q;
                    end
                end
                ST_SUPER: begin
                    // The first dominant bit costs 8, then each further run of 8
                    if (bus.RX) begin
                        state_d   = ST_DELIM;
                        bit_cnt_d = CNT_W'(1);
                    end else if (super_first_q) begin
                        inc_dom_s     = 1'b1;
                        super_first_d = 1'b0;
                        dom_cnt_d     = 3'd0;
                    end else if (dom_cnt_q == DOM_RUN_LAST) begin
                        inc_dom_s = 1'b1;
                        dom_cnt_d = 3'd0;
                    end else begin
                        dom_cnt_d = dom_cnt_q + 3'd1;
                    end
                end
                ST_DELIM: begin
                    if (bus.RX) begin
                        bit_cnt_d = bit_cnt_inc_s;
                        if (bit_cnt_inc_s == DELIM_LAST) begin
                            state_d    = ST_IDLE;
                            err_done_d = 1'b1;
                        end else begin
                            err_done_d = 1'b0;
                        end
                    end else begin
                        state_d        = ST_FLAG;
                        bit_cnt_d      = {CNT_W{1'b0}};
                        inc_err_s      = 1'b1;
                        flag_passive_d = passive_s;
                        tx_err_d       = passive_s;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    tx_err_d = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        err_active_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= {CNT_W{1'b0}};
            dom_cnt_q      <= 3'd0;
            super_first_q  <= 1'b0;
            flag_passive_q <= 1'b0;
            tx_err_q       <= 1'b1;
            err_active_q   <= 1'b0;
            err_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            dom_cnt_q      <= dom_cnt_d;
            super_first_q  <= super_first_d;
            flag_passive_q <= flag_passive_d;
            tx_err_q       <= tx_err_d;
            err_active_q   <= err_active_d;
            err_done_q     <= err_done_d;
        end
    end

    error_frame_block_rec_counter #(
        .REC_W (REC_W)
    ) u_rec_counter (
        .clock       (clock),
        .reset       (reset),
        .inc_err     (inc_err_s),
        .inc_dom     (inc_dom_s),
        .dec         (dec_s),
        .rec         (rec_s),
        .err_passive (passive_s)
    );

    assign bus.TX_ERR      = tx_err_q;
    assign bus.ERR_ACTIVE  = err_active_q;
    assign bus.ERR_DONE    = err_done_q;
    assign bus.REC         = rec_s;
    assign bus.ERR_PASSIVE = passive_s;

endmodule

// File: tb/tb_error_frame_block.sv
// Directed bench for error_frame_block: each task drives sample points and
// compares the outputs against hand-computed values.
module tb_error_frame_block;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic       tx_s, act_s, done_s, pas_s, done_late_s;
    logic [7:0] rec_s;

    always #5 clock = ~clock;

    error_frame_block_if #(.REC_W(8)) bus ();

    error_frame_block #(
        .FLAG_LEN  (6),
        .DELIM_LEN (8),
        .REC_W     (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // One sample point; outputs captured on the following falling edge
    task automatic sp(input logic rx, input logic err_n, input logic fok);
        @(negedge clock);
        bus.SP = 1'b1; bus.RX = rx; bus.ERROR = err_n; bus.FRAME_OK = fok;
        @(negedge clock);
        bus.SP = 1'b0; bus.ERROR = 1'b1; bus.FRAME_OK = 1'b0;
        tx_s = bus.TX_ERR; act_s = bus.ERR_ACTIVE; done_s = bus.ERR_DONE;
        rec_s = bus.REC; pas_s = bus.ERR_PASSIVE;
        @(negedge clock);
        done_late_s = bus.ERR_DONE;
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        bus.SP = 1'b0; bus.RX = 1'b1; bus.ERROR = 1'b1; bus.FRAME_OK = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic run_frame(input int dom_n);
        sp(1'b1, 1'b0, 1'b0);
        repeat (6) sp(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < dom_n; k++) sp(1'b0, 1'b1, 1'b0);
        repeat (8) sp(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        bus.SP = 1'b0; bus.RX = 1'b1; bus.ERROR = 1'b1; bus.FRAME_OK = 1'b0;
        #12;
        n_cmp++; if (bus.TX_ERR !== 1'b1) begin n_bad++; $display("FAIL rst_tx got %b want 1", bus.TX_ERR); end
        n_cmp++; if (bus.ERR_ACTIVE !== 1'b0) begin n_bad++; $display("FAIL rst_active got %b want 0", bus.ERR_ACTIVE); end
        n_cmp++; if (bus.ERR_DONE !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.ERR_DONE); end
        n_cmp++; if (bus.REC !== 8'd0) begin n_bad++; $display("FAIL rst_rec got %0d want 0", bus.REC); end
        n_cmp++; if (bus.ERR_PASSIVE !== 1'b0) begin n_bad++; $display("FAIL rst_passive got %b want 0", bus.ERR_PASSIVE); end
        @(negedge clock);
        reset = 1'b1;
        sp(1'b1, 1'b0, 1'b0);
        sp(1'b0, 1'b1, 1'b0);
        sp(1'b0, 1'b1, 1'b0);
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL rst_midflag_tx got %b want 0", tx_s); end
        n_cmp++; if (rec_s !== 8'd1) begin n_bad++; $display("FAIL rst_midflag_rec got %0d want 1", rec_s); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.TX_ERR !== 1'b1) begin n_bad++; $display("FAIL rst_async_tx got %b want 1", bus.TX_ERR); end
        n_cmp++; if (bus.ERR_ACTIVE !== 1'b0) begin n_bad++; $display("FAIL rst_async_active got %b want 0", bus.ERR_ACTIVE); end
        n_cmp++; if (bus.REC !== 8'd0) begin n_bad++; $display("FAIL rst_async_rec got %0d want 0", bus.REC); end
        @(negedge clock);
        reset = 1'b1;
        sp(1'b1, 1'b1, 1'b0);
        n_cmp++; if (act_s !== 1'b0) begin n_bad++; $display("FAIL rst_idle_active got %b want 0", act_s); end
        sp(1'b1, 1'b0, 1'b0);
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL rst_newerr_tx got %b want 0", tx_s); end
        n_cmp++; if (rec_s !== 8'd1) begin n_bad++; $display("FAIL rst_newerr_rec got %0d want 1", rec_s); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        sp(1'b1, 1'b0, 1'b0);
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL basic_first_tx got %b want 0", tx_s); end
        n_cmp++; if (act_s !== 1'b1) begin n_bad++; $display("FAIL basic_first_active got %b want 1", act_s); end
        n_cmp++; if (rec_s !== 8'd1) begin n_bad++; $display("FAIL basic_first_rec got %0d want 1", rec_s); end
        for (int i = 1; i <= 6; i++) begin
            sp(1'b0, (i == 3) ? 1'b0 : 1'b1, 1'b0);
            n_cmp++; if (tx_s !== (i == 6)) begin n_bad++; $display("FAIL basic_flag_tx sp%0d got %b want %b", i, tx_s, (i == 6)); end
            n_cmp++; if (act_s !== 1'b1) begin n_bad++; $display("FAIL basic_flag_active sp%0d got %b want 1", i, act_s); end
        end
        for (int i = 7; i <= 14; i++) begin
            sp(1'b1, 1'b1, 1'b0);
            n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL basic_delim_tx sp%0d got %b want 1", i, tx_s); end
            n_cmp++; if (done_s !== (i == 14)) begin n_bad++; $display("FAIL basic_done sp%0d got %b want %b", i, done_s, (i == 14)); end
            n_cmp++; if (act_s !== (i != 14)) begin n_bad++; $display("FAIL basic_active sp%0d got %b want %b", i, act_s, (i != 14)); end
        end
        n_cmp++; if (done_late_s !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done_late_s); end
        n_cmp++; if (rec_s !== 8'd1) begin n_bad++; $display("FAIL basic_rec got %0d want 1", rec_s); end
    endtask

    task automatic test_superposition();
        logic [7:0] exp_rec;
        do_reset();
        sp(1'b1, 1'b0, 1'b0);
        repeat (6) sp(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            sp(1'b0, 1'b1, 1'b0);
            exp_rec = (i == 9) ? 8'd17 : 8'd9;
            n_cmp++; if (rec_s !== exp_rec) begin n_bad++; $display("FAIL super_rec dom%0d got %0d want %0d", i, rec_s, exp_rec); end
            n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL super_tx dom%0d got %b want 1", i, tx_s); end
        end
        for (int j = 1; j <= 8; j++) begin
            sp(1'b1, 1'b1, 1'b0);
            n_cmp++; if (done_s !== (j == 8)) begin n_bad++; $display("FAIL super_done rec%0d got %b want %b", j, done_s, (j == 8)); end
        end
        n_cmp++; if (rec_s !== 8'd17) begin n_bad++; $display("FAIL super_final_rec got %0d want 17", rec_s); end
    endtask

    task automatic test_passive();
        do_reset();
        for (int f = 1; f <= 14; f++) run_frame(1);
        n_cmp++; if (rec_s !== 8'd126) begin n_bad++; $display("FAIL pas_rec14 got %0d want 126", rec_s); end
        sp(1'b1, 1'b0, 1'b0);
        n_cmp++; if (rec_s !== 8'd127) begin n_bad++; $display("FAIL pas_rec127 got %0d want 127", rec_s); end
        n_cmp++; if (pas_s !== 1'b0) begin n_bad++; $display("FAIL pas_at127 got %b want 0", pas_s); end
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL pas_active_flag got %b want 0", tx_s); end
        repeat (7) sp(1'b0, 1'b1, 1'b0);
        n_cmp++; if (rec_s !== 8'd135) begin n_bad++; $display("FAIL pas_rec135 got %0d want 135", rec_s); end
        n_cmp++; if (pas_s !== 1'b1) begin n_bad++; $display("FAIL pas_at135 got %b want 1", pas_s); end
        repeat (8) sp(1'b1, 1'b1, 1'b0);
        n_cmp++; if (done_s !== 1'b1) begin n_bad++; $display("FAIL pas_done15 got %b want 1", done_s); end
        sp(1'b1, 1'b0, 1'b0);
        n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL pas_flag_tx got %b want 1", tx_s); end
        n_cmp++; if (act_s !== 1'b1) begin n_bad++; $display("FAIL pas_flag_active got %b want 1", act_s); end
        n_cmp++; if (rec_s !== 8'd136) begin n_bad++; $display("FAIL pas_rec136 got %0d want 136", rec_s); end
        for (int i = 1; i <= 6; i++) begin
            sp(1'b0, 1'b1, 1'b0);
            n_cmp++; if (tx_s !== 1'b1) begin n_bad++; $display("FAIL pas_hold_tx sp%0d got %b want 1", i, tx_s); end
        end
        repeat (8) sp(1'b1, 1'b1, 1'b0);
        n_cmp++; if (done_s !== 1'b1) begin n_bad++; $display("FAIL pas_done16 got %b want 1", done_s); end
        sp(1'b1, 1'b1, 1'b1);
        n_cmp++; if (rec_s !== 8'd120) begin n_bad++; $display("FAIL pas_recover got %0d want 120", rec_s); end
        n_cmp++; if (pas_s !== 1'b0) begin n_bad++; $display("FAIL pas_recover_flag got %b want 0", pas_s); end
        sp(1'b1, 1'b1, 1'b1);
        n_cmp++; if (rec_s !== 8'd119) begin n_bad++; $display("FAIL pas_decrement got %0d want 119", rec_s); end
    endtask

    task automatic test_delim_form_error();
        do_reset();
        sp(1'b1, 1'b0, 1'b0);
        repeat (6) sp(1'b0, 1'b1, 1'b0);
        repeat (3) sp(1'b1, 1'b1, 1'b0);
        sp(1'b0, 1'b1, 1'b0);
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL dfe_tx got %b want 0", tx_s); end
        n_cmp++; if (act_s !== 1'b1) begin n_bad++; $display("FAIL dfe_active got %b want 1", act_s); end
        n_cmp++; if (done_s !== 1'b0) begin n_bad++; $display("FAIL dfe_done got %b want 0", done_s); end
        n_cmp++; if (rec_s !== 8'd2) begin n_bad++; $display("FAIL dfe_rec got %0d want 2", rec_s); end
        for (int i = 1; i <= 6; i++) begin
            sp(1'b0, 1'b1, 1'b0);
            n_cmp++; if (tx_s !== (i == 6)) begin n_bad++; $display("FAIL dfe_flag_tx sp%0d got %b want %b", i, tx_s, (i == 6)); end
        end
        for (int j = 1; j <= 8; j++) begin
            sp(1'b1, 1'b1, 1'b0);
            n_cmp++; if (done_s !== (j == 8)) begin n_bad++; $display("FAIL dfe_done2 rec%0d got %b want %b", j, done_s, (j == 8)); end
        end
        n_cmp++; if (rec_s !== 8'd2) begin n_bad++; $display("FAIL dfe_final_rec got %0d want 2", rec_s); end
    endtask

    task automatic test_simultaneous_and_saturation();
        do_reset();
        repeat (5) run_frame(0);
        n_cmp++; if (rec_s !== 8'd5) begin n_bad++; $display("FAIL sim_rec5 got %0d want 5", rec_s); end
        sp(1'b1, 1'b0, 1'b1);
        n_cmp++; if (rec_s !== 8'd6) begin n_bad++; $display("FAIL sim_err_wins got %0d want 6", rec_s); end
        n_cmp++; if (tx_s !== 1'b0) begin n_bad++; $display("FAIL sim_tx got %b want 0", tx_s); end
        repeat (6) sp(1'b0, 1'b1, 1'b0);
        repeat (8) sp(1'b1, 1'b1, 1'b0);
        sp(1'b1, 1'b1, 1'b1);
        n_cmp++; if (rec_s !== 8'd5) begin n_bad++; $display("FAIL sim_dec got %0d want 5", rec_s); end
        do_reset();
        run_frame(241);
        n_cmp++; if (rec_s !== 8'd249) begin n_bad++; $display("FAIL sat_long_dom got %0d want 249", rec_s); end
        run_frame(0);
        n_cmp++; if (rec_s !== 8'd250) begin n_bad++; $display("FAIL sat_rec250 got %0d want 250", rec_s); end
        sp(1'b1, 1'b0, 1'b0);
        n_cmp++; if (rec_s !== 8'd251) begin n_bad++; $display("FAIL sat_rec251 got %0d want 251", rec_s); end
        repeat (7) sp(1'b0, 1'b1, 1'b0);
        n_cmp++; if (rec_s !== 8'd255) begin n_bad++; $display("FAIL sat_dom got %0d want 255", rec_s); end
        repeat (8) sp(1'b1, 1'b1, 1'b0);
        sp(1'b1, 1'b0, 1'b0);
        n_cmp++; if (rec_s !== 8'd255) begin n_bad++; $display("FAIL sat_err got %0d want 255", rec_s); end
        repeat (6) sp(1'b0, 1'b1, 1'b0);
        repeat (8) sp(1'b1, 1'b1, 1'b0);
        sp(1'b1, 1'b1, 1'b1);
        n_cmp++; if (rec_s !== 8'd120) begin n_bad++; $display("FAIL sat_recover got %0d want 120", rec_s); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_superposition();
        test_passive();
        test_delim_form_error();
        test_simultaneous_and_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
